// File: rtl/multdiv_sequencer.sv
// Sequencer between the DX stage and the multi-cycle multdiv unit: latches operands, pulses start,
// stalls the front end and arbitrates for the regfile write port. Optional watchdog: MDIV_TIMEOUT_EN.
module multdiv_sequencer #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned TIMEOUT = 40
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic              issue_is_div,
  input  logic [DATA_W-1:0] issue_a,
  input  logic [DATA_W-1:0] issue_b,
  input  logic [REG_W-1:0]  issue_rd,
  output logic              issue_ack,
  output logic              stall,
  output logic [DATA_W-1:0] md_a,
  output logic [DATA_W-1:0] md_b,
  output logic              md_ctrl_mult,
  output logic              md_ctrl_div,
  input  logic [DATA_W-1:0] md_result,
  input  logic              md_exception,
  input  logic              md_rdy,
  output logic              wb_valid,
  input  logic              wb_grant,
  output logic [REG_W-1:0]  wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              timeout
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY,
    DONE
  } state_t;

  localparam logic [REG_W-1:0]  STATUS_REG = REG_W'(30);
  localparam logic [DATA_W-1:0] MULT_CODE  = DATA_W'(4);
  localparam logic [DATA_W-1:0] DIV_CODE   = DATA_W'(5);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("multdiv_sequencer: TIMEOUT must be in 1..255");
  end

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   a_q, b_q, result_q;
  logic [REG_W-1:0]    rd_q;
  logic                is_div_q, exc_q;
  logic                limit_hit;

`ifdef MDIV_TIMEOUT_EN
  logic [7:0] busy_cnt_q;

  // Counter holds the number of BUSY cycles already elapsed, so the limit fires in the TIMEOUT-th one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_cnt_q <= '0;
    end else if (state_q == START) begin
      busy_cnt_q <= '0;
    end else if (state_q == BUSY) begin
      busy_cnt_q <= busy_cnt_q + 8'd1;
    end
  end

  assign limit_hit = (busy_cnt_q == 8'(TIMEOUT - 1));
`else
  assign limit_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    issue_ack    = 1'b0;
    stall        = 1'b0;
    md_ctrl_mult = 1'b0;
    md_ctrl_div  = 1'b0;
    wb_valid     = 1'b0;
    wb_reg       = '0;
    wb_data      = '0;
    timeout      = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue_valid) begin
          issue_ack = 1'b1;
          stall     = 1'b1;
          state_d   = START;
        end
      end
      START: begin
        stall        = 1'b1;
        md_ctrl_mult = ~is_div_q;
        md_ctrl_div  = is_div_q;
        state_d      = BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        if (md_rdy) begin
          state_d = DONE;
        end else if (limit_hit) begin
          timeout = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        wb_valid = 1'b1;
        wb_reg   = exc_q ? STATUS_REG : rd_q;
        wb_data  = exc_q ? (is_div_q ? DIV_CODE : MULT_CODE) : result_q;
        stall    = ~wb_grant;
        if (wb_grant) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // issue_valid reaches the outputs combinationally in IDLE; hold them low while reset is asserted.
    if (!reset) begin
      issue_ack = 1'b0;
      stall     = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      rd_q     <= '0;
      is_div_q <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && issue_valid) begin
        a_q      <= issue_a;
        b_q      <= issue_b;
        rd_q     <= issue_rd;
        is_div_q <= issue_is_div;
      end
      if (state_q == BUSY) begin
        if (md_rdy) begin
          result_q <= md_result;
          exc_q    <= md_exception;
        end else if (limit_hit) begin
          exc_q <= 1'b1;
        end
      end
    end
  end

  assign md_a = a_q;
  assign md_b = b_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed + randomized bench for multdiv_sequencer; emulates the multdiv unit and checks writebacks
// against arithmetic computed here. Timeout step depends on MDIV_TIMEOUT_EN.
module tb_multdiv_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_is_div = 1'b0;
  logic [31:0] issue_a = '0;
  logic [31:0] issue_b = '0;
  logic [4:0]  issue_rd = '0;
  logic        issue_ack, stall;
  logic [31:0] md_a, md_b;
  logic        md_ctrl_mult, md_ctrl_div;
  logic [31:0] md_result = '0;
  logic        md_exception = 1'b0;
  logic        md_rdy = 1'b0;
  logic        wb_valid;
  logic        wb_grant = 1'b0;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        timeout;

  multdiv_sequencer #(.DATA_W(32), .REG_W(5), .TIMEOUT(40)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_is_div(issue_is_div),
    .issue_a(issue_a), .issue_b(issue_b), .issue_rd(issue_rd),
    .issue_ack(issue_ack), .stall(stall),
    .md_a(md_a), .md_b(md_b),
    .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
    .md_result(md_result), .md_exception(md_exception), .md_rdy(md_rdy),
    .wb_valid(wb_valid), .wb_grant(wb_grant),
    .wb_reg(wb_reg), .wb_data(wb_data), .timeout(timeout)
  );

  always #5 clock = ~clock;

  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned ack_cnt = 0, mult_cnt = 0, div_cnt = 0;

  always @(negedge clock) begin
    if (issue_ack)    ack_cnt++;
    if (md_ctrl_mult) mult_cnt++;
    if (md_ctrl_div)  div_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] ref_result(input bit is_div, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    if (is_div) return a / b;
    p = {32'd0, a} * {32'd0, b};
    return p[31:0];
  endfunction

  // One complete op: issue, start, multdiv latency, writeback after gdly ungranted DONE cycles.
  task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int unsigned lat, input bit exc,
                        input int unsigned gdly, input bit hold);
    logic [31:0] res, exp_data;
    logic [4:0]  exp_reg;
    int unsigned m0, d0, a0;
    res      = exc ? $urandom : ref_result(is_div, a, b);
    exp_reg  = exc ? 5'd30 : rd;
    exp_data = exc ? (is_div ? 32'd5 : 32'd4) : res;
    m0 = mult_cnt; d0 = div_cnt; a0 = ack_cnt;

    issue_valid = 1'b1; issue_is_div = is_div; issue_a = a; issue_b = b; issue_rd = rd;
    #1;
    check("issue_ack", issue_ack, 1);
    check("stall_issue", stall, 1);
    tick();
    issue_valid = hold; issue_is_div = ~is_div;
    issue_a = $urandom; issue_b = $urandom; issue_rd = 5'($urandom);
    md_rdy = 1'b1; md_result = $urandom; md_exception = 1'b1;
    #1;
    check("start_mult", md_ctrl_mult, !is_div);
    check("start_div", md_ctrl_div, is_div);
    check("md_a", md_a, a);
    check("md_b", md_b, b);
    check("ack_in_start", issue_ack, 0);
    tick();
    md_rdy = 1'b0; md_exception = 1'b0;
    for (int i = 1; i < int'(lat); i++) tick();
    check("busy_no_wb", wb_valid, 0);
    check("md_a_stable", md_a, a);
    md_rdy = 1'b1; md_result = res; md_exception = exc;
    tick();
    md_rdy = 1'b0; md_result = $urandom; md_exception = 1'b0;
    for (int i = 0; i < int'(gdly); i++) begin
      check("wait_valid", wb_valid, 1);
      check("wait_reg", wb_reg, exp_reg);
      check("wait_data", wb_data, exp_data);
      check("wait_stall", stall, 1);
      tick();
    end
    wb_grant = 1'b1;
    #1;
    check("wb_valid", wb_valid, 1);
    check("wb_reg", wb_reg, exp_reg);
    check("wb_data", wb_data, exp_data);
    check("stall_on_grant", stall, 0);
    tick();
    wb_grant = 1'b0;
    check("wb_valid_clr", wb_valid, 0);
    check("mult_pulses", mult_cnt - m0, is_div ? 0 : 1);
    check("div_pulses", div_cnt - d0, is_div ? 1 : 0);
    check("ack_count", ack_cnt - a0, 1);
    check("idle_stall", stall, hold);
    if (hold) check("second_ack", issue_ack, 1);
    issue_valid = 1'b0;
    #1;
  endtask

  initial begin
    bit          dv, ex;
    logic [31:0] ra, rb;
    int unsigned m0, d0, seen;

    #1;
    check("reset_outs", {26'd0, stall, issue_ack, wb_valid, md_ctrl_mult, md_ctrl_div, timeout}, 0);
    check("reset_md_a", md_a, 0);
    check("reset_wb", {wb_reg, wb_data[26:0]}, 0);
    tick(); tick();
    @(negedge clock); reset = 1'b1;
    tick();

    run_op(1'b0, 32'd7, 32'd6, 5'd3, 33, 1'b0, 0, 1'b0);
    run_op(1'b1, 32'd100, 32'd0, 5'd5, 12, 1'b1, 0, 1'b0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd3, 5'd9, 5, 1'b0, 3, 1'b0);
    run_op(1'b1, 32'd1000, 32'd7, 5'd17, 1, 1'b0, 1, 1'b1);

    for (int n = 0; n < 14; n++) begin
      dv = 1'($urandom);
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      ex = dv ? (rb == 0) : ($urandom_range(0, 7) == 0);
      run_op(dv, ra, rb, 5'($urandom_range(1, 31)), $urandom_range(1, 40), ex,
             $urandom_range(0, 4), 1'($urandom_range(0, 3) == 0));
    end

    // Reset asserted mid-BUSY
    m0 = mult_cnt; d0 = div_cnt;
    issue_valid = 1'b1; issue_is_div = 1'b0; issue_a = 32'd11; issue_b = 32'd13; issue_rd = 5'd4;
    tick(); issue_valid = 1'b0;
    tick(); tick(); tick();
    #2 reset = 1'b0;
    #1;
    check("rst_mid_outs", {26'd0, stall, issue_ack, wb_valid, md_ctrl_mult, md_ctrl_div, timeout}, 0);
    check("rst_mid_md", md_a | md_b, 0);
    check("rst_mid_wb", {wb_reg, wb_data[26:0]}, 0);
    @(negedge clock); reset = 1'b1;
    md_rdy = 1'b1; md_result = 32'd143;
    tick(); tick(); tick();
    md_rdy = 1'b0;
    check("post_rst_wb", wb_valid, 0);
    check("post_rst_stall", stall, 0);
    check("post_rst_pulses", (mult_cnt - m0) + (div_cnt - d0), 1);

    // No md_rdy at all
    issue_valid = 1'b1; issue_is_div = 1'b0; issue_a = 32'd2; issue_b = 32'd3; issue_rd = 5'd8;
    tick(); issue_valid = 1'b0;
    tick();
`ifdef MDIV_TIMEOUT_EN
    seen = 0;
    for (int i = 1; i <= 45; i++) begin
      if (timeout) begin
        seen = i;
        break;
      end
      tick();
    end
    check("timeout_cycle", seen, 40);
    tick();
    check("timeout_pulse_len", timeout, 0);
    check("timeout_wb_reg", wb_reg, 30);
    check("timeout_wb_data", wb_data, 4);
`else
    for (int i = 0; i < 60; i++) tick();
    check("no_timeout", timeout, 0);
    check("stall_persists", stall, 1);
    check("no_wb_yet", wb_valid, 0);
    md_rdy = 1'b1; md_result = 32'd6; md_exception = 1'b0;
    tick();
    md_rdy = 1'b0;
    check("late_wb_reg", wb_reg, 8);
    check("late_wb_data", wb_data, 6);
`endif
    wb_grant = 1'b1;
    tick();
    wb_grant = 1'b0;
    check("final_idle", {wb_valid, stall}, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
